// File: rtl/id_scoreboard_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard sequencer.
//   fsmState_t : branch-flush FSM encoding (RUN = 0, FLUSH = 1)
//   REG_ZERO   : hard-wired zero register, never tracked by the scoreboard
package id_scoreboard_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fsmState_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/sb_counter_bank.sv
// Bank of per-register pending-write counters.
// Ports:
//   Clk, Reset    : clock, asynchronous active-low reset
//   incEn, incIdx : one register gains an in-flight write this cycle
//   decEn, decIdx : one register retires a write this cycle
//   counts        : live counter values, one CNT_W slice per register
//   decUnderflow  : retire aimed at a register whose count is already zero
// Counters saturate in both directions. An increment and a decrement that
// target the same register cancel and leave the count unchanged.
module sb_counter_bank #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2,
  parameter int IDX_W    = 5
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             incEn,
  input  logic [IDX_W-1:0]                 incIdx,
  input  logic                             decEn,
  input  logic [IDX_W-1:0]                 decIdx,
  output logic [NUM_REGS-1:0][CNT_W-1:0]   counts,
  output logic                             decUnderflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [NUM_REGS-1:0]            incHit;
  logic [NUM_REGS-1:0]            decHit;

  always_comb begin
    incHit = '0;
    decHit = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      incHit[i] = incEn && (incIdx == IDX_W'(i));
      decHit[i] = decEn && (decIdx == IDX_W'(i));
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (incHit[i] && !decHit[i] && cnt[i] != CNT_MAX) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (decHit[i] && !incHit[i] && cnt[i] != '0) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  assign counts       = cnt;
  assign decUnderflow = decEn && (cnt[decIdx] == '0);

endmodule

// File: rtl/id_scoreboard_ctrl.sv
// ID-stage hazard sequencer: tracks in-flight register writes, stalls ID on
// RAW hazards or a saturated counter, and squashes wrong-path fetches after a
// taken branch.
// Ports:
//   Clk, Reset                 : clock, asynchronous active-low reset
//   id_valid/rs/rt/uses_rs/uses_rt/writes/dest : current ID instruction
//   wb_valid, wb_dest          : register file write in WB this cycle
//   br_resolve, br_taken       : branch outcome
//   stall      : hold PC and IF/ID
//   bubble     : zero ID/EX control fields
//   flush_ifid : clear IF/ID
//   stall_count: stall cycles since reset (wraps)
//   sb_error   : sticky, retire seen for a register with nothing pending
//   dbgState   : branch-flush FSM state
module id_scoreboard_ctrl
  import id_scoreboard_ctrl_pkg::*;
#(
  parameter int NUM_REGS     = 32,
  parameter int CNT_W        = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        id_valid,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rs,
  input  logic        id_uses_rt,
  input  logic        id_writes,
  input  logic [4:0]  id_dest,
  input  logic        wb_valid,
  input  logic [4:0]  wb_dest,
  input  logic        br_resolve,
  input  logic        br_taken,
  output logic        stall,
  output logic        bubble,
  output logic        flush_ifid,
  output logic [31:0] stall_count,
  output logic        sb_error,
  output fsmState_t   dbgState
);

  localparam logic [CNT_W-1:0] CNT_MAX      = '1;
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [2:0]       FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  fsmState_t  state, stateNext;
  logic [2:0] fcnt, fcntNext;

  logic [NUM_REGS-1:0][CNT_W-1:0] counts;
  logic [CNT_W-1:0] cntRs, cntRt, cntDest;
  logic wbHitRs, wbHitRt, wbHitDest;
  logic hazRs, hazRt, full;
  logic issue, retire, underflow, brTaken;

  assign cntRs   = counts[id_rs];
  assign cntRt   = counts[id_rt];
  assign cntDest = counts[id_dest];

  // A WB write this cycle lands before the ID read, so it satisfies exactly
  // one pending write to that register.
  assign wbHitRs   = wb_valid && (wb_dest == id_rs);
  assign wbHitRt   = wb_valid && (wb_dest == id_rt);
  assign wbHitDest = wb_valid && (wb_dest == id_dest);

  assign hazRs = id_uses_rs && (id_rs != REG_ZERO) &&
                 ((cntRs > CNT_ONE) || ((cntRs == CNT_ONE) && !wbHitRs));
  assign hazRt = id_uses_rt && (id_rt != REG_ZERO) &&
                 ((cntRt > CNT_ONE) || ((cntRt == CNT_ONE) && !wbHitRt));
  // Saturated counter: issuing would lose track of a write, unless WB frees a slot.
  assign full  = id_writes && (id_dest != REG_ZERO) && (cntDest == CNT_MAX) && !wbHitDest;

  assign stall      = (state == RUN) && id_valid && (hazRs || hazRt || full);
  assign bubble     = stall || (state == FLUSH);
  assign flush_ifid = (state == FLUSH);
  assign dbgState   = state;

  assign issue   = (state == RUN) && id_valid && !stall && id_writes && (id_dest != REG_ZERO);
  assign retire  = wb_valid && (wb_dest != REG_ZERO);
  assign brTaken = br_resolve && br_taken;

  sb_counter_bank #(
    .NUM_REGS (NUM_REGS),
    .CNT_W    (CNT_W),
    .IDX_W    (5)
  ) u_bank (
    .Clk          (Clk),
    .Reset        (Reset),
    .incEn        (issue),
    .incIdx       (id_dest),
    .decEn        (retire),
    .decIdx       (wb_dest),
    .counts       (counts),
    .decUnderflow (underflow)
  );

  // Flush FSM: fcnt holds the flush cycles remaining after the current one.
  always_comb begin
    stateNext = state;
    fcntNext  = fcnt;
    case (state)
      RUN: begin
        if (brTaken) begin
          stateNext = FLUSH;
          fcntNext  = FLUSH_RELOAD;
        end
      end
      FLUSH: begin
        if (brTaken) begin
          fcntNext = FLUSH_RELOAD;
        end else if (fcnt == 3'd0) begin
          stateNext = RUN;
        end else begin
          fcntNext = fcnt - 3'd1;
        end
      end
      default: begin
        stateNext = RUN;
        fcntNext  = 3'd0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state       <= RUN;
      fcnt        <= 3'd0;
      stall_count <= 32'd0;
      sb_error    <= 1'b0;
    end else begin
      state <= stateNext;
      fcnt  <= fcntNext;
      if (stall) begin
        stall_count <= stall_count + 32'd1;
      end
      if (underflow) begin
        sb_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
module tb_id_scoreboard_ctrl;
  import id_scoreboard_ctrl_pkg::*;

  localparam int FC   = 2;
  localparam int MAXP = 3;

  // clock / reset
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  always #5 Clk = ~Clk;

  logic        id_valid, id_uses_rs, id_uses_rt, id_writes;
  logic [4:0]  id_rs, id_rt, id_dest, wb_dest;
  logic        wb_valid, br_resolve, br_taken;
  logic        stall, bubble, flush_ifid, sb_error;
  logic [31:0] stall_count;
  fsmState_t   dbgState;

  id_scoreboard_ctrl #(
    .NUM_REGS     (32),
    .CNT_W        (2),
    .FLUSH_CYCLES (FC)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .id_writes   (id_writes),
    .id_dest     (id_dest),
    .wb_valid    (wb_valid),
    .wb_dest     (wb_dest),
    .br_resolve  (br_resolve),
    .br_taken    (br_taken),
    .stall       (stall),
    .bubble      (bubble),
    .flush_ifid  (flush_ifid),
    .stall_count (stall_count),
    .sb_error    (sb_error),
    .dbgState    (dbgState)
  );

  // scoreboard state and reference model
  int          total = 0;
  int          bad = 0;
  int          pend [32];
  int          flushLeft;
  logic [31:0] mStallCnt;
  bit          mErr;
  logic [31:0] exp_q[$];

  task automatic check1(input string tag, input logic obs, input logic expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    flushLeft = 0;
    mStallCnt = 32'd0;
    mErr      = 1'b0;
  endtask

  // Writes to register r still unresolved once this cycle's WB has landed.
  function automatic int outstanding(input int r);
    int left;
    left = pend[r];
    if (wb_valid && int'(wb_dest) == r) left = left - 1;
    return left;
  endfunction

  // driver tasks
  task automatic idle();
    id_valid = 0; id_uses_rs = 0; id_uses_rt = 0; id_writes = 0;
    id_rs = 0; id_rt = 0; id_dest = 0;
    wb_valid = 0; wb_dest = 0; br_resolve = 0; br_taken = 0;
  endtask

  // Called at a negedge with inputs already applied: checks all outputs
  // against the model, crosses one rising edge, advances the model.
  task automatic cycle(input string tag);
    bit inFlush, hz, expStall, doIssue, doRetire, taken;
    int dIdx, wIdx;
    #1;
    inFlush  = flushLeft > 0;
    hz       = (id_uses_rs && id_rs != 0 && outstanding(int'(id_rs)) > 0) ||
               (id_uses_rt && id_rt != 0 && outstanding(int'(id_rt)) > 0) ||
               (id_writes && id_dest != 0 && outstanding(int'(id_dest)) >= MAXP);
    expStall = !inFlush && id_valid && hz;
    check1({tag, ".stall"}, stall, expStall);
    check1({tag, ".bubble"}, bubble, expStall || inFlush);
    check1({tag, ".flush"}, flush_ifid, inFlush);
    check32({tag, ".stall_count"}, stall_count, mStallCnt);
    check1({tag, ".sb_error"}, sb_error, mErr);
    doIssue  = !inFlush && id_valid && !expStall && id_writes && id_dest != 0;
    doRetire = wb_valid && wb_dest != 0;
    taken    = br_resolve && br_taken;
    dIdx     = int'(id_dest);
    wIdx     = int'(wb_dest);
    @(posedge Clk);
    if (doRetire && pend[wIdx] == 0) mErr = 1'b1;
    if (!(doIssue && doRetire && dIdx == wIdx)) begin
      if (doIssue) pend[dIdx]++;
      if (doRetire && pend[wIdx] > 0) pend[wIdx]--;
    end
    if (expStall) mStallCnt++;
    if (taken) flushLeft = FC;
    else if (flushLeft > 0) flushLeft--;
    @(negedge Clk);
  endtask

  task automatic pick_wb();
    int start, r;
    wb_valid = 1'b0;
    wb_dest  = 5'd0;
    if ($urandom_range(0, 2) != 0) return;
    wb_valid = 1'b1;
    if ($urandom_range(0, 15) == 0) begin
      wb_dest = 5'($urandom_range(0, 7));
      return;
    end
    start = $urandom_range(1, 7);
    for (int k = 0; k < 7; k++) begin
      r = 1 + ((start - 1 + k) % 7);
      if (pend[r] > 0) begin
        wb_dest = 5'(r);
        return;
      end
    end
    wb_valid = 1'b0;
  endtask

  initial begin
    idle();
    model_reset();
    #2;
    check1("reset.stall", stall, 1'b0);
    check1("reset.bubble", bubble, 1'b0);
    check1("reset.flush", flush_ifid, 1'b0);
    check32("reset.stall_count", stall_count, 32'd0);
    check1("reset.sb_error", sb_error, 1'b0);
    @(negedge Clk);
    Reset = 1'b1;

    // RAW on $8, released by same-cycle WB bypass
    id_valid = 1; id_writes = 1; id_dest = 8;
    cycle("t1_issue");
    id_writes = 0; id_uses_rs = 1; id_rs = 8;
    #1 check1("t1_stall", stall, 1'b1);
    check1("t1_bubble", bubble, 1'b1);
    cycle("t1_s0");
    cycle("t1_s1");
    wb_valid = 1; wb_dest = 8;
    #1 check1("t1_bypass", stall, 1'b0);
    cycle("t1_wb");
    idle();
    #1 check32("t1_count", stall_count, 32'd2);
    cycle("t1_idle");

    // register zero is never tracked
    id_valid = 1; id_writes = 1; id_dest = 0;
    repeat (4) cycle("t2_issue0");
    id_uses_rs = 1; id_rs = 0; id_uses_rt = 1; id_rt = 0;
    #1 check1("t2_nostall", stall, 1'b0);
    cycle("t2_read0");
    idle(); wb_valid = 1; wb_dest = 0;
    cycle("t2_wb0");
    idle();
    #1 check1("t2_noerr", sb_error, 1'b0);
    cycle("t2_idle");

    // saturated counter on $5
    id_valid = 1; id_writes = 1; id_dest = 5;
    repeat (3) cycle("t3_issue");
    #1 check1("t3_full", stall, 1'b1);
    cycle("t3_full0");
    cycle("t3_full1");
    wb_valid = 1; wb_dest = 5;
    #1 check1("t3_retire_frees", stall, 1'b0);
    cycle("t3_swap");
    idle(); wb_valid = 1; wb_dest = 5;
    repeat (3) cycle("t3_drain");
    idle();

    // taken branch: two flush cycles, ID writes squashed
    br_resolve = 1; br_taken = 1;
    #1 check1("t4_br_cycle", flush_ifid, 1'b0);
    cycle("t4_br");
    idle(); id_valid = 1; id_writes = 1; id_dest = 10;
    exp_q = '{32'd1, 32'd1};
    while (exp_q.size() > 0) begin
      #1 check1("t4_flush", flush_ifid, exp_q.pop_front() != 0);
      cycle("t4_fl");
    end
    idle();
    #1 check1("t4_after", flush_ifid, 1'b0);
    cycle("t4_run");
    id_valid = 1; id_uses_rs = 1; id_rs = 10;
    #1 check1("t4_no_issue", stall, 1'b0);
    cycle("t4_read10");
    // second taken branch in the first flush cycle extends the flush
    idle(); br_resolve = 1; br_taken = 1;
    cycle("t4_br2a");
    #1 check1("t4_ext0", flush_ifid, 1'b1);
    cycle("t4_br2b");
    idle();
    exp_q = '{32'd1, 32'd1, 32'd0};
    while (exp_q.size() > 0) begin
      #1 check1("t4_ext", flush_ifid, exp_q.pop_front() != 0);
      cycle("t4_ex");
    end

    // retire with nothing pending: sticky error, cleared only by reset
    wb_valid = 1; wb_dest = 9;
    cycle("t5_bad_retire");
    idle();
    #1 check1("t5_err", sb_error, 1'b1);
    cycle("t5_hold0");
    cycle("t5_hold1");
    #1 check1("t5_err_sticky", sb_error, 1'b1);
    Reset = 1'b0;
    #1 check1("t5_async_clear", sb_error, 1'b0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;

    // reset during a stall
    id_valid = 1; id_writes = 1; id_dest = 12;
    cycle("t6_issue");
    id_writes = 0; id_uses_rs = 1; id_rs = 12;
    #1 check1("t6_stall_pre", stall, 1'b1);
    Reset = 1'b0;
    #1 check1("t6_stall_drop", stall, 1'b0);
    check1("t6_bubble_drop", bubble, 1'b0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
    cycle("t6_after_stall");

    // reset during a flush
    idle(); br_resolve = 1; br_taken = 1;
    cycle("t6_br");
    idle();
    #1 check1("t6_flush_pre", flush_ifid, 1'b1);
    Reset = 1'b0;
    #1 check1("t6_flush_drop", flush_ifid, 1'b0);
    check1("t6_state_run", dbgState == RUN, 1'b1);
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
    cycle("t6_after_flush");

    // randomized traffic on a small register window
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        Reset = 1'b0;
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
      end
      id_valid   = ($urandom_range(0, 3) != 0);
      id_rs      = 5'($urandom_range(0, 7));
      id_rt      = 5'($urandom_range(0, 7));
      id_uses_rs = 1'($urandom_range(0, 1));
      id_uses_rt = 1'($urandom_range(0, 1));
      id_writes  = 1'($urandom_range(0, 1));
      id_dest    = 5'($urandom_range(0, 7));
      pick_wb();
      br_resolve = ($urandom_range(0, 9) == 0);
      br_taken   = 1'($urandom_range(0, 1));
      cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
